// File: rtl/led_7seg_pkg.sv
// Shared segment constants for the 7-segment scan driver.
// All codes are active-low, bit6..bit0 = g,f,e,d,c,b,a.
package led_7seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1011000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/led_7seg_hex_decoder.sv
// Nibble to active-low 7-segment code; codes 10..15 blank
// unless HEX_MODE is set.
module led_7seg_hex_decoder
    import led_7seg_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        unique case (code)
            4'd0:  seg_n = SEG_0;
            4'd1:  seg_n = SEG_1;
            4'd2:  seg_n = SEG_2;
            4'd3:  seg_n = SEG_3;
            4'd4:  seg_n = SEG_4;
            4'd5:  seg_n = SEG_5;
            4'd6:  seg_n = SEG_6;
            4'd7:  seg_n = SEG_7;
            4'd8:  seg_n = SEG_8;
            4'd9:  seg_n = SEG_9;
            4'd10: seg_n = HEX_MODE ? SEG_A : SEG_BLANK;
            4'd11: seg_n = HEX_MODE ? SEG_B : SEG_BLANK;
            4'd12: seg_n = HEX_MODE ? SEG_C : SEG_BLANK;
            4'd13: seg_n = HEX_MODE ? SEG_D : SEG_BLANK;
            4'd14: seg_n = HEX_MODE ? SEG_E : SEG_BLANK;
            4'd15: seg_n = HEX_MODE ? SEG_F : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led_7seg_scan_driver.sv
// Multiplexed 7-segment scan driver with shadow registers,
// anti-ghost blanking and leading-zero suppression.
module led_7seg_scan_driver
    import led_7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 2,
    parameter bit HEX_MODE       = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_BLANK : 7'b0;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        DIG_ACTIVE_LOW ? '1 : '0;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dpin_q, dpin_d;
    logic                    blz_q, blz_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                    frame_tick_q, frame_tick_d;

    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  lz_bit;
    logic [NUM_DIGITS-1:0] lz;
    logic [NUM_DIGITS-1:0] onehot;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_raw;
    logic                  slot_on;
    logic                  blank_digit;
    logic                  dp_on;
    logic                  lead;

    led_7seg_hex_decoder #(
        .HEX_MODE(HEX_MODE)
    ) u_dec (
        .code (nib),
        .seg_n(dec_seg)
    );

    // lz[k]: every shadow nibble from the top down to k is zero
    always_comb begin
        lz   = '0;
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead  = lead & (digits_q[4*k +: 4] == 4'd0);
            lz[k] = lead;
        end
    end

    always_comb begin
        nib    = 4'd0;
        dp_bit = 1'b0;
        lz_bit = 1'b0;
        onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib       = digits_q[4*k +: 4];
                dp_bit    = dpin_q[k];
                lz_bit    = lz[k];
                onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d        = cnt_q + CW'(1);
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d        = '0;
            idx_d        = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
            frame_tick_d = (idx_q == IDX_MAX);
        end

        digits_d = load ? digits_in : digits_q;
        dpin_d   = load ? dp_in     : dpin_q;
        blz_d    = load ? blank_lz  : blz_q;

        slot_on     = (cnt_q >= BLANK_END);
        blank_digit = blz_q && (idx_q != '0) && lz_bit;
        seg_raw     = blank_digit ? SEG_BLANK : dec_seg;
        dp_on       = slot_on && dp_bit && !blank_digit;

        seg_d    = SEG_ACTIVE_LOW ? seg_raw : ~seg_raw;
        dp_d     = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
        dig_en_d = DIG_ACTIVE_LOW ? ~(slot_on ? onehot : '0)
                                  : (slot_on ? onehot : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            digits_q     <= '0;
            dpin_q       <= '0;
            blz_q        <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            dig_en_q     <= DIG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            digits_q     <= digits_d;
            dpin_q       <= dpin_d;
            blz_q        <= blz_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_en_q     <= dig_en_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_en     = dig_en_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_7seg_scan_driver.sv
// Scoreboard bench for the scan driver: decimal and hex
// instances share stimulus, a time-based model predicts outputs.
module tb_led_7seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg, seg_h;
    logic        dp, dp_h;
    logic [3:0]  dig_en, dig_en_h;
    logic        frame_tick, frame_tick_h;

    always #5 clk = ~clk;

    led_7seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .HEX_MODE(1'b0),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp),
        .dig_en(dig_en), .frame_tick(frame_tick)
    );

    led_7seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .HEX_MODE(1'b1),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u_dut_hex (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_h), .dp(dp_h),
        .dig_en(dig_en_h), .frame_tick(frame_tick_h)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [6:0] seg_h;
        logic       dp;
        logic [3:0] dig_en;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_bad   = 0;

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };
    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          m_t;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic        m_bz;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
        end
    endtask

    function automatic exp_t predict(input bit r);
        exp_t e;
        int   c, s;
        logic [3:0] nb;
        logic blank, on;
        if (r) begin
            e.seg = 7'h7F; e.seg_h = 7'h7F; e.dp = 1'b1;
            e.dig_en = 4'hF; e.ft = 1'b0;
            return e;
        end
        c     = m_t % 8;
        s     = (m_t / 8) % 4;
        nb    = m_dig[4*s +: 4];
        blank = m_bz && (s >= 1) && ((m_dig >> (4*s)) == 16'h0);
        on    = (c >= 2);
        e.seg    = blank ? 7'h7F : dec_tab[nb];
        e.seg_h  = blank ? 7'h7F : hex_tab[nb];
        e.dig_en = on ? ~(4'b0001 << s) : 4'hF;
        e.dp     = (on && m_dp[s] && !blank) ? 1'b0 : 1'b1;
        e.ft     = ((m_t % 32) == 31);
        return e;
    endfunction

    task automatic step(input bit r, input bit ld, input logic [15:0] d,
                        input logic [3:0] p, input bit bz);
        exp_t e;
        rst = r; load = ld; digits_in = d; dp_in = p; blank_lz = bz;
        exp_q.push_back(predict(r));
        if (r) begin
            m_t = 0; m_dig = '0; m_dp = '0; m_bz = 1'b0;
        end else begin
            m_t++;
            if (ld) begin
                m_dig = d; m_dp = p; m_bz = bz;
            end
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("seg",        {25'b0, seg},        {25'b0, e.seg});
        check("seg_hex",    {25'b0, seg_h},      {25'b0, e.seg_h});
        check("dp",         {31'b0, dp},         {31'b0, e.dp});
        check("dig_en",     {28'b0, dig_en},     {28'b0, e.dig_en});
        check("frame_tick", {31'b0, frame_tick}, {31'b0, e.ft});
        check("ft_hex",     {31'b0, frame_tick_h}, {31'b0, e.ft});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    initial begin
        m_t = 0; m_dig = '0; m_dp = '0; m_bz = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(70);

        step(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
        idle(40);

        step(1'b0, 1'b1, 16'h0050, 4'b0000, 1'b1);
        idle(32);
        step(1'b0, 1'b1, 16'h0050, 4'b0000, 1'b0);
        idle(32);

        step(1'b0, 1'b1, 16'h00AF, 4'b0101, 1'b0);
        idle(32);

        for (int i = 0; i < 40 && (m_t % 32) != 21; i++) idle(1);
        step(1'b0, 1'b1, 16'h8888, 4'b0100, 1'b0);
        idle(30);

        for (int i = 0; i < 10 && (m_t % 8) != 7; i++) idle(1);
        step(1'b0, 1'b1, 16'h9076, 4'b1010, 1'b1);
        idle(20);

        for (int i = 0; i < 10 && (m_t % 8) != 3; i++) idle(1);
        step(1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b1);
        idle(36);

        for (int i = 0; i < 120; i++) begin
            step(1'b0, ($urandom_range(0, 3) == 0),
                 16'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/led_7seg_scan_driver.md
LED_7SEG_SCAN_DRIVER -- requirements
Module: led_7seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digit count, range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clocks per digit slot, at least 4.
REQ-003 SHALL have parameter BLANK_CYC, default 2: anti-ghost blank clocks at the start of each slot, less than SCAN_DIV.
REQ-004 SHALL have parameter HEX_MODE, default 0: 1 decodes codes 10..15 as A,b,C,d,E,F; 0 blanks them.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1: polarity of seg and dp.
REQ-006 SHALL have parameter DIG_ACTIVE_LOW, default 1: polarity of dig_en.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port load, input, 1 bit: capture digits_in, dp_in and blank_lz.
REQ-010 SHALL have port digits_in, input, 4*NUM_DIGITS bits: nibble k is digit k; digit 0 is least significant.
REQ-011 SHALL have port dp_in, input, NUM_DIGITS bits: decimal point per digit.
REQ-012 SHALL have port blank_lz, input, 1 bit: leading-zero suppression enable.
REQ-013 SHALL have port seg, output, 7 bits: bit6..bit0 = g,f,e,d,c,b,a.
REQ-014 SHALL have port dp, output, 1 bit: decimal point of the active digit.
REQ-015 SHALL have port dig_en, output, NUM_DIGITS bits: one-hot digit enable.
REQ-016 SHALL have port frame_tick, output, 1 bit: one-cycle pulse per completed scan frame.

Function
REQ-017 SHALL latch digits_in, dp_in and blank_lz into shadow registers on the clk edge where load=1; a load on any cycle is accepted.
REQ-018 SHALL keep a prescaler cnt counting 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL wrap to 0 and advance scan index idx.
REQ-019 SHALL wrap idx from NUM_DIGITS-1 to 0, and SHALL assert frame_tick on the cycle after that wrap for exactly one cycle.
REQ-020 SHALL register all outputs: seg, dp and dig_en reflect the cnt, idx and shadow values of the preceding cycle.
REQ-021 SHALL drive dig_en active only for bit idx, and only while cnt >= BLANK_CYC; otherwise all bits inactive.
REQ-022 SHALL decode codes 0..9 in active-low form as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000.
REQ-023 SHALL decode hex codes, when HEX_MODE=1, as: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 SHALL drive seg all-off for codes 10..15 when HEX_MODE=0; no latch and no undefined output is permitted.
REQ-025 SHALL blank digit k (seg all-off, dp off) when shadow blank_lz=1 and shadow nibbles NUM_DIGITS-1..k are all zero, for k >= 1; digit 0 is never blanked.
REQ-026 SHALL drive dp from shadow dp_in[idx], and SHALL drive dp inactive when dig_en is all inactive.
REQ-027 SHALL invert seg and dp when SEG_ACTIVE_LOW=0, and SHALL invert dig_en when DIG_ACTIVE_LOW=0.
REQ-028 SHALL display the new value on a load arriving mid-slot starting from the next output update; the scan timing SHALL NOT be disturbed.
REQ-029 SHALL treat load coinciding with a slot wrap as: the new idx uses the new shadow data.

Reset
REQ-030 SHALL, while rst=1, clear cnt, idx and the shadow registers, and deassert frame_tick.
REQ-031 SHALL, while rst=1, drive seg, dp and dig_en all inactive on the following cycle; rst has priority over load.
REQ-032 SHALL, on the first cycle after rst deasserts, start at cnt=0, idx=0.

Structure
REQ-033 SHALL place the segment code constants (0..9, A..F, blank) in package led_7seg_pkg.
REQ-034 SHALL use one combinational sub-module, led_7seg_hex_decoder (4-bit code and HEX_MODE in, 7-bit active-low code out), instantiated once on the muxed nibble.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, default polarities)
REQ-035 SHALL cover: load digits_in=16'h1234 -> digit0 slot seg=0011001, digit3 slot seg=1111001; dig_en=1110 for 6 of 8 clocks, 1111 for 2.
REQ-036 SHALL cover: free run after reset -> frame_tick pulses every 32 clocks, one cycle wide; dig_en order 1110,1101,1011,0111.
REQ-037 SHALL cover: blank_lz=1, digits_in=16'h0050 -> digits 3,2 blank, digit1=0010010, digit0=1000000; with blank_lz=0, digits 3,2=1000000.
REQ-038 SHALL cover: HEX_MODE=0 with digits_in=16'h00AF -> digits 1,0 blank; HEX_MODE=1 -> 0001000 and 0001110.
REQ-039 SHALL cover: rst asserted mid-slot with load=1 in the same cycle -> next cycle seg=1111111, dig_en=1111, dp=1; shadow=0.
REQ-040 SHALL cover: load 16'h8888 at cnt=5 of slot 2 -> the slot 2 remainder shows 0000000 from the following update; frame_tick timing unchanged.
